estagio_busca_if: RTL and testbench
===================================

// Module: estagio_busca_if
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID pipeline register.
//  Owns the PC, fetches one word per request over a req/ack instruction-memory port and
//  presents {instruction, PC+4, valid} to IF/ID. Honours hazard-unit stall and EX branch/jump redirect.
// PARAMETERS
//  PC_INICIAL  32'h0000_0000  PC value loaded on reset
//  NOP         32'h0000_0000  instrucaoOut value whenever validoOut=0
// PORTS
//  clock           in   1   single clock; all state updates on rising edge
//  reset           in   1   synchronous, active-low reset
//  stall           in   1   hazard unit: IF/ID not accepting this cycle
//  desvio          in   1   one-cycle redirect pulse (taken branch/jump)
//  enderecoDesvio  in   32  redirect target, sampled when desvio=1
//  memReq          out  1   instruction-memory request
//  memEndereco     out  32  fetch address; stable while memReq=1
//  memAck          in   1   memory returns memDado this cycle (may be same cycle as memReq)
//  memDado         in   32  fetched word, valid when memAck=1
//  instrucaoOut    out  32  instruction to IF/ID
//  pcSomadoOut     out  32  address of instrucaoOut + 4, to IF/ID
//  validoOut       out  1   instrucaoOut/pcSomadoOut hold a live instruction
//  pcAtual         out  32  current PC (debug/trace)
//  erroAlinhamento out  1   only with IF_ALINHAMENTO_EN; sticky misaligned-target flag
// BEHAVIOUR
//  - Reset (reset=0 at edge): PC<=PC_INICIAL, state<=OCIOSO, memReq=0, memEndereco=PC_INICIAL,
//    instrucaoOut<=NOP, pcSomadoOut<=0, validoOut<=0, erroAlinhamento<=0. Ack in reset cycle ignored.
//  - Consumed = validoOut & ~stall. memEndereco=PC always; memReq=1 only in BUSCA and DESCARTE.
//  - FSM: OCIOSO  -> BUSCA unconditionally (one dead cycle after reset).
//         BUSCA   memReq=1. On memAck (no desvio): instrucaoOut<=memDado, pcSomadoOut<=PC+4,
//                 validoOut<=1, PC<=PC+4; stay BUSCA if not stalled, else -> SEGURA.
//                 No ack: hold; if validoOut & ~stall this cycle, validoOut<=0, instrucaoOut<=NOP.
//                 BUSCA entered only when output slot free or being consumed; one outstanding request max.
//         SEGURA  memReq=0, outputs frozen; when stall=0 -> BUSCA (output consumed that cycle).
//         DESCARTE memReq=1 on stale address until memAck; ack data dropped; then PC<=saved target, -> BUSCA.
//  - Zero-wait memory (memAck same cycle): one instruction per cycle, latency req->validoOut = 1 cycle.
//  - desvio has priority over stall and memAck: validoOut<=0, instrucaoOut<=NOP (flush, even if stalled).
//    If no request pending or ack arrives same cycle (data dropped): PC<=enderecoDesvio, -> BUSCA.
//    If request pending without ack: save target, -> DESCARTE (request never withdrawn mid-handshake).
//    desvio in DESCARTE overwrites saved target.
//  - PC+4 arithmetic modulo 2^32: PC 32'hFFFF_FFFC -> 32'h0000_0000, pcSomadoOut=0.
//  - reset mid-request: memReq=0 next cycle, late ack ignored in OCIOSO.
// CONFIGURATION
//  IF_ALINHAMENTO_EN defined: desvio with enderecoDesvio[1:0]!=0 sets erroAlinhamento=1 (sticky to reset),
//    flushes output, FSM enters PARADO (memReq=0, validoOut=0) until reset; PC not loaded.
//  Not defined: port absent, enderecoDesvio[1:0] treated as 2'b00, no PARADO state.
// TESTING
//  1 Reset, zero-wait mem returning addr-as-data -> memReq high from cycle 2; validoOut=1,
//    instrucaoOut=0x0/0x4/0x8, pcSomadoOut=0x4/0x8/0xC on consecutive cycles.
//  2 stall=1 for 3 cycles while validoOut=1 -> outputs frozen, memReq=0, PC unchanged; resume with next addr.
//  3 Mem ack delayed 3 cycles, desvio to 0x100 in cycle 1 of wait -> memEndereco stable until ack,
//    ack data dropped, next fetch addr 0x100, validoOut=0 meanwhile.
//  4 desvio to 0x40 with stall=1 and memAck=1 same cycle -> validoOut=0 next cycle, next fetch 0x40.
//  5 PC_INICIAL=32'hFFFF_FFFC -> first pcSomadoOut=0, second fetch address 0x0.
//  6 With IF_ALINHAMENTO_EN, desvio to 0x102 -> erroAlinhamento=1, memReq=0 until reset=0.

Source files
------------

// File: rtl/estagio_busca_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | estagio_busca_if : MIPS IF stage (PC, req/ack fetch, stall, redirect)     |
// | Optional IF_ALINHAMENTO_EN: misaligned redirect halts stage.  Rev 1.0     |
// +--------------------------------------------------------------------------+
module estagio_busca_if #(
  parameter logic [31:0] PC_INICIAL = 32'h0000_0000,
  parameter logic [31:0] NOP        = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        desvio,
  input  logic [31:0] enderecoDesvio,
  output logic        memReq,
  output logic [31:0] memEndereco,
  input  logic        memAck,
  input  logic [31:0] memDado,
  output logic [31:0] instrucaoOut,
  output logic [31:0] pcSomadoOut,
  output logic        validoOut,
  output logic [31:0] pcAtual
`ifdef IF_ALINHAMENTO_EN
  ,
  output logic        erroAlinhamento
`endif
);

`ifdef IF_ALINHAMENTO_EN
  typedef enum logic [2:0] {
    OCIOSO = 3'd0, BUSCA = 3'd1, SEGURA = 3'd2, DESCARTE = 3'd3, PARADO = 3'd4
  } estado_t;
`else
  typedef enum logic [1:0] {
    OCIOSO = 2'd0, BUSCA = 2'd1, SEGURA = 2'd2, DESCARTE = 2'd3
  } estado_t;
`endif

  estado_t     estado_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_somado_q;
  logic [31:0] alvo_q;
  logic        valido_q;
  logic [31:0] pc_mais4;
  logic [31:0] alvo_alinhado;
  logic        pendente;
  logic        ativo;

  assign pc_mais4     = pc_q + 32'd4;
  assign memReq       = (estado_q == BUSCA) || (estado_q == DESCARTE);
  assign memEndereco  = pc_q;
  assign pcAtual      = pc_q;
  assign instrucaoOut = instr_q;
  assign pcSomadoOut  = pc_somado_q;
  assign validoOut    = valido_q;
  // A request still waiting for its ack cannot be withdrawn on redirect.
  assign pendente     = memReq & ~memAck;

`ifdef IF_ALINHAMENTO_EN
  logic erro_q;
  logic desalinhado;
  assign alvo_alinhado   = enderecoDesvio;
  assign desalinhado     = |enderecoDesvio[1:0];
  assign ativo           = (estado_q != PARADO);
  assign erroAlinhamento = erro_q;
`else
  logic unused_lsb;
  assign alvo_alinhado = {enderecoDesvio[31:2], 2'b00};
  assign unused_lsb    = ^enderecoDesvio[1:0];
  assign ativo         = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q    <= OCIOSO;
      pc_q        <= PC_INICIAL;
      instr_q     <= NOP;
      pc_somado_q <= 32'h0;
      alvo_q      <= 32'h0;
      valido_q    <= 1'b0;
`ifdef IF_ALINHAMENTO_EN
      erro_q      <= 1'b0;
`endif
    end else if (desvio && ativo) begin
      valido_q <= 1'b0;
      instr_q  <= NOP;
`ifdef IF_ALINHAMENTO_EN
      if (desalinhado) begin
        erro_q   <= 1'b1;
        estado_q <= PARADO;
      end else
`endif
      if (pendente) begin
        alvo_q   <= alvo_alinhado;
        estado_q <= DESCARTE;
      end else begin
        pc_q     <= alvo_alinhado;
        estado_q <= BUSCA;
      end
    end else begin
      case (estado_q)
        OCIOSO: estado_q <= BUSCA;
        BUSCA: begin
          if (memAck) begin
            // Occupied, stalled slot: drop the word and refetch the same PC later.
            if (valido_q && stall) begin
              estado_q <= SEGURA;
            end else begin
              instr_q     <= memDado;
              pc_somado_q <= pc_mais4;
              pc_q        <= pc_mais4;
              valido_q    <= 1'b1;
              estado_q    <= stall ? SEGURA : BUSCA;
            end
          end else if (valido_q && !stall) begin
            valido_q <= 1'b0;
            instr_q  <= NOP;
          end
        end
        SEGURA: begin
          if (!stall) begin
            valido_q <= 1'b0;
            instr_q  <= NOP;
            estado_q <= BUSCA;
          end
        end
        DESCARTE: begin
          if (memAck) begin
            pc_q     <= alvo_q;
            estado_q <= BUSCA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_estagio_busca_if.sv
`default_nettype none
// Bench for estagio_busca_if: directed scenarios plus random stall/redirect/ack
// traffic, checked every cycle against a rule-level model of two instances.
module tb_estagio_busca_if;

  localparam logic [31:0] CHAVE = 32'hA500_0000;   // memory returns addr ^ CHAVE

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, stall, desvio;
  logic [31:0] enderecoDesvio;
  logic        memAck1, memAck2;
  logic [31:0] memDado1, memDado2;
  logic        memReq1, memReq2, val1, val2;
  logic [31:0] memEnd1, memEnd2, instr1, instr2, pcs1, pcs2, pcA1, pcA2;
  logic        err1, err2;

  int total = 0;
  int bad   = 0;
  int lat1  = -1;
  int lat_fixa = -1;

  estagio_busca_if #(.PC_INICIAL(32'h0000_0000), .NOP(32'h0000_0000)) dut1 (
    .clock(clock), .reset(reset), .stall(stall), .desvio(desvio),
    .enderecoDesvio(enderecoDesvio), .memReq(memReq1), .memEndereco(memEnd1),
    .memAck(memAck1), .memDado(memDado1), .instrucaoOut(instr1),
    .pcSomadoOut(pcs1), .validoOut(val1), .pcAtual(pcA1)
`ifdef IF_ALINHAMENTO_EN
    , .erroAlinhamento(err1)
`endif
  );

  estagio_busca_if #(.PC_INICIAL(32'hFFFF_FFFC), .NOP(32'h0000_0000)) dut2 (
    .clock(clock), .reset(reset), .stall(stall), .desvio(desvio),
    .enderecoDesvio(enderecoDesvio), .memReq(memReq2), .memEndereco(memEnd2),
    .memAck(memAck2), .memDado(memDado2), .instrucaoOut(instr2),
    .pcSomadoOut(pcs2), .validoOut(val2), .pcAtual(pcA2)
`ifdef IF_ALINHAMENTO_EN
    , .erroAlinhamento(err2)
`endif
  );

`ifndef IF_ALINHAMENTO_EN
  assign err1 = 1'b0;
  assign err2 = 1'b0;
`endif

  // fase: 0 dead cycle after reset, 1 fetching, 2 holding, 3 discarding, 4 halted
  typedef struct packed {
    logic [31:0] pc, instr, pcs, alvo;
    logic        valid, err;
    logic [2:0]  fase;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t passo(mdl_t m, logic [31:0] pc0, logic rn, logic st,
                                 logic dv, logic [31:0] tg, logic ack, logic [31:0] dado);
    mdl_t n = m;
    logic req = (m.fase == 3'd1) || (m.fase == 3'd3);
    logic [31:0] alvo = tg & ~32'd3;
    if (!rn) begin
      n = '0;
      n.pc = pc0;
      return n;
    end
    if (m.fase == 3'd4) return n;
    if (dv) begin
      n.valid = 1'b0;
      n.instr = 32'h0;
`ifdef IF_ALINHAMENTO_EN
      if (tg[1:0] != 2'b00) begin
        n.err  = 1'b1;
        n.fase = 3'd4;
        return n;
      end
`endif
      if (req && !ack) begin
        n.alvo = alvo;
        n.fase = 3'd3;
      end else begin
        n.pc   = alvo;
        n.fase = 3'd1;
      end
      return n;
    end
    case (m.fase)
      3'd0: n.fase = 3'd1;
      3'd1: begin
        if (ack) begin
          if (m.valid && st) n.fase = 3'd2;
          else begin
            n.instr = dado;
            n.pcs   = m.pc + 32'd4;
            n.pc    = m.pc + 32'd4;
            n.valid = 1'b1;
            n.fase  = st ? 3'd2 : 3'd1;
          end
        end else if (m.valid && !st) begin
          n.valid = 1'b0;
          n.instr = 32'h0;
        end
      end
      3'd2: if (!st) begin
        n.valid = 1'b0;
        n.instr = 32'h0;
        n.fase  = 3'd1;
      end
      3'd3: if (ack) begin
        n.pc   = m.alvo;
        n.fase = 3'd1;
      end
      default: ;
    endcase
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic verifica(input string n, input mdl_t m, input logic rq, input logic [31:0] ad,
                          input logic [31:0] ins, input logic [31:0] pcs, input logic v,
                          input logic [31:0] pa, input logic er);
    chk({n, ".memReq"}, {31'b0, rq}, {31'b0, (m.fase == 3'd1) || (m.fase == 3'd3)});
    chk({n, ".memEndereco"}, ad, m.pc);
    chk({n, ".pcAtual"}, pa, m.pc);
    chk({n, ".instrucaoOut"}, ins, m.instr);
    chk({n, ".pcSomadoOut"}, pcs, m.pcs);
    chk({n, ".validoOut"}, {31'b0, v}, {31'b0, m.valid});
`ifdef IF_ALINHAMENTO_EN
    chk({n, ".erroAlinhamento"}, {31'b0, er}, {31'b0, m.err});
`else
    if (er !== 1'b0) chk({n, ".erroTie"}, {31'b0, er}, 32'h0);
`endif
  endtask

  // One clock: choose memory responses, drive inputs, advance models, check outputs.
  task automatic ciclo(input logic rn, input logic st, input logic dv, input logic [31:0] tg);
    logic a1;
    if (memReq1) begin
      if (lat1 < 0) lat1 = (lat_fixa >= 0) ? lat_fixa : int'($urandom_range(0, 2));
      a1 = (lat1 == 0);
      if (a1) lat1 = -1;
      else lat1--;
    end else begin
      lat1 = -1;
      a1 = ($urandom_range(0, 3) == 0);   // stray ack, must be ignored
    end
    reset = rn; stall = st; desvio = dv; enderecoDesvio = tg;
    memAck1  = a1;
    memDado1 = memEnd1 ^ CHAVE;
    memAck2  = memReq2 ? 1'b1 : 1'($urandom_range(0, 1));
    memDado2 = memEnd2 ^ CHAVE;
    m1 = passo(m1, 32'h0000_0000, rn, st, dv, tg, memAck1, memDado1);
    m2 = passo(m2, 32'hFFFF_FFFC, rn, st, dv, tg, memAck2, memDado2);
    @(posedge clock);
    @(negedge clock);
    verifica("u1", m1, memReq1, memEnd1, instr1, pcs1, val1, pcA1, err1);
    verifica("u2", m2, memReq2, memEnd2, instr2, pcs2, val2, pcA2, err2);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; desvio = 1'b0; enderecoDesvio = 32'h0;
    memAck1 = 1'b0; memAck2 = 1'b0; memDado1 = 32'h0; memDado2 = 32'h0;
    m1 = '0; m2 = '0;
    @(negedge clock);

    // Reset then zero-wait fetch stream
    lat_fixa = 0;
    ciclo(1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset.memReq", {31'b0, memReq1}, 32'h0);
    chk("reset.valid", {31'b0, val1}, 32'h0);
    ciclo(1'b1, 1'b0, 1'b0, 32'h0);
    chk("dead.memReq", {31'b0, memReq1}, 32'h1);
    ciclo(1'b1, 1'b0, 1'b0, 32'h0);
    chk("s1.instr", instr1, CHAVE);
    chk("s1.pcs", pcs1, 32'h4);
    chk("wrap.pcs", pcs2, 32'h0);
    chk("wrap.addr", memEnd2, 32'h0);
    ciclo(1'b1, 1'b0, 1'b0, 32'h0);
    chk("s2.instr", instr1, CHAVE ^ 32'h4);
    ciclo(1'b1, 1'b0, 1'b0, 32'h0);
    chk("s3.pcs", pcs1, 32'hC);

    // Stall for three cycles while the output is live
    repeat (3) ciclo(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall.instr", instr1, CHAVE ^ 32'h8);
    chk("stall.pc", memEnd1, 32'hC);
    ciclo(1'b1, 1'b0, 1'b0, 32'h0);
    chk("resume.req", {31'b0, memReq1}, 32'h1);

    // Slow memory with a redirect during the wait
    lat_fixa = 3;
    ciclo(1'b1, 1'b0, 1'b0, 32'h0);
    ciclo(1'b1, 1'b0, 1'b1, 32'h100);
    ciclo(1'b1, 1'b0, 1'b0, 32'h0);
    chk("disc.addr", memEnd1, 32'hC);
    chk("disc.valid", {31'b0, val1}, 32'h0);
    ciclo(1'b1, 1'b0, 1'b0, 32'h0);
    chk("disc.target", memEnd1, 32'h100);

    // Redirect beats stall and ack in the same cycle
    lat_fixa = 0;
    ciclo(1'b1, 1'b0, 1'b0, 32'h0);
    ciclo(1'b1, 1'b1, 1'b1, 32'h40);
    chk("prio.valid", {31'b0, val1}, 32'h0);
    chk("prio.addr", memEnd1, 32'h40);

    // Reset in the middle of a slow request
    lat_fixa = 3;
    ciclo(1'b1, 1'b0, 1'b0, 32'h0);
    ciclo(1'b0, 1'b0, 1'b0, 32'h0);
    chk("midreset.req", {31'b0, memReq1}, 32'h0);
    ciclo(1'b1, 1'b0, 1'b0, 32'h0);

    lat_fixa = -1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom & 32'h0000_0FFF;
`ifdef IF_ALINHAMENTO_EN
      t[1:0] = 2'b00;
`endif
      ciclo(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) == 0), t);
    end

    // Misaligned redirect
    ciclo(1'b0, 1'b0, 1'b0, 32'h0);
    ciclo(1'b1, 1'b0, 1'b0, 32'h0);
    ciclo(1'b1, 1'b0, 1'b1, 32'h102);
`ifdef IF_ALINHAMENTO_EN
    chk("align.err", {31'b0, err1}, 32'h1);
    repeat (3) ciclo(1'b1, 1'b0, 1'b0, 32'h0);
    chk("align.halt", {31'b0, memReq1}, 32'h0);
    ciclo(1'b0, 1'b0, 1'b0, 32'h0);
    chk("align.clear", {31'b0, err1}, 32'h0);
`else
    chk("align.mask", memEnd1, 32'h100);
    ciclo(1'b1, 1'b0, 1'b0, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
